// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Its controls are combinational from state and inputs, so a stall acts in the cycle it is seen.
// A data-memory wait freezes the whole pipe. A wait that runs past MEM_TIMEOUT cycles latches FAULT, which only reset clears.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nxt;
    logic [4:0]          en;      // {pc, ifid, idex, exmem, memwb}
    logic [1:0]          flush;   // {ifid, idex}
    logic                resolve;
    logic                load_use;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        en           = 5'b11111;
        flush        = 2'b00;
        resolve      = 1'b0;

        case (state)
            RUN: begin
                if (i_mem_req && !i_mem_ack) begin
                    en           = 5'b00000;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (i_mem_ack) begin
                    resolve      = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt < WAIT_W'(MEM_TIMEOUT)) begin
                    en           = 5'b00000;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    en        = 5'b00000;
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                en = 5'b00000;
            end
            default: begin
                en        = 5'b00000;
                state_nxt = RUN;
            end
        endcase

        // The branch held in the frozen EX stage is applied on the cycle the pipe moves again.
        if (resolve) begin
            if (i_ex_br_taken) begin
                flush = 2'b11;
            end else if (load_use) begin
                en    = 5'b00111;
                flush = 2'b01;
            end
        end

        if (i_rst) begin
            en    = 5'b00000;
            flush = 2'b00;
        end
    end

    assign o_pc_en      = en[4];
    assign o_ifid_en    = en[3];
    assign o_idex_en    = en[2];
    assign o_exmem_en   = en[1];
    assign o_memwb_en   = en[0];
    assign o_ifid_flush = flush[1] && en[3];
    assign o_idex_flush = flush[0] && en[2];
    assign o_fault      = (state == FAULT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (!o_pc_en && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks of pipe_hazard_ctrl: hazards, branch priority, memory wait, timeout, reset and counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ack;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, fault;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_fault;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_br_taken(ex_br_taken),
        .i_mem_req(mem_req), .i_mem_ack(mem_ack),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en),
        .o_exmem_en(exmem_en), .o_memwb_en(memwb_en),
        .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
        .o_fault(fault), .o_stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_br_taken(ex_br_taken),
        .i_mem_req(mem_req), .i_mem_ack(mem_ack),
        .o_pc_en(s_pc_en), .o_ifid_en(s_ifid_en), .o_idex_en(s_idex_en),
        .o_exmem_en(s_exmem_en), .o_memwb_en(s_memwb_en),
        .o_ifid_flush(s_ifid_flush), .o_idex_flush(s_idex_flush),
        .o_fault(s_fault), .o_stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] en_v();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    function automatic logic [1:0] fl_v();
        return {ifid_flush, idex_flush};
    endfunction

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Leaves the bench at negedge+1 with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // Reset state: everything forced low while reset is held.
        @(negedge clk); #1;
        check("rst_en", en_v(), 5'b00000);
        check("rst_flush", fl_v(), 2'b00);
        check("rst_fault", fault, 1'b0);
        check("rst_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_en", en_v(), 5'b11111);

        // Load-use through rs2.
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1;
        check("lu_rs2_en", en_v(), 5'b00111);
        check("lu_rs2_flush", fl_v(), 2'b01);
        check("lu_rs2_cnt0", stall_cnt, 16'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("lu_rs2_cnt1", stall_cnt, 16'd1);
        check("lu_clear_en", en_v(), 5'b11111);

        // Load-use through rs1, then a match with the use flag low.
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        #1;
        check("lu_rs1_en", en_v(), 5'b00111);
        @(negedge clk);
        id_use_rs1 = 1'b0;
        #1;
        check("lu_nouse_en", en_v(), 5'b11111);
        check("lu_rs1_cnt", stall_cnt, 16'd2);

        // Branch beats a simultaneous load-use hazard.
        @(negedge clk);
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; ex_br_taken = 1'b1;
        #1;
        check("br_en", en_v(), 5'b11111);
        check("br_flush", fl_v(), 2'b11);

        // A load to x0 with a matching source is not a hazard.
        @(negedge clk);
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        check("x0_en", en_v(), 5'b11111);
        check("x0_flush", fl_v(), 2'b00);

        // Ack without req, and req with ack in the same cycle, both leave the pipe running.
        @(negedge clk);
        clear_inputs();
        mem_ack = 1'b1;
        #1;
        check("ack_noreq_en", en_v(), 5'b11111);
        @(negedge clk);
        mem_req = 1'b1;
        #1;
        check("req_ack_en", en_v(), 5'b11111);
        @(negedge clk);
        clear_inputs();
        #1;
        check("req_ack_cnt", stall_cnt, 16'd2);

        // Memory wait for 3 cycles with a held branch, applied on the ack cycle.
        do_reset();
        @(negedge clk);
        mem_req = 1'b1; ex_br_taken = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("wait_en_%0d", k), en_v(), 5'b00000);
            check($sformatf("wait_flush_%0d", k), fl_v(), 2'b00);
            @(negedge clk);
        end
        mem_ack = 1'b1;
        #1;
        check("ack_en", en_v(), 5'b11111);
        check("ack_flush", fl_v(), 2'b11);
        check("ack_cnt", stall_cnt, 16'd3);
        @(negedge clk);
        clear_inputs();
        #1;
        check("post_ack_en", en_v(), 5'b11111);
        check("post_ack_cnt", stall_cnt, 16'd3);

        // Reset asserted mid-wait clears outputs at once.
        @(negedge clk);
        mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midwait_en", en_v(), 5'b00000);
        rst = 1'b1;
        #1;
        check("midrst_en", en_v(), 5'b00000);
        check("midrst_cnt", stall_cnt, 16'd0);
        check("midrst_fault", fault, 1'b0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        check("midrst_run_en", en_v(), 5'b11111);
        check("midrst_run_fault", fault, 1'b0);
        check("midrst_run_cnt", stall_cnt, 16'd0);

        // Timeout into FAULT after 16 stalled cycles, plus 4-bit counter saturation.
        @(negedge clk);
        mem_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (k == 1 || k == 16 || k == 20) check($sformatf("to_en_%0d", k), en_v(), 5'b00000);
            @(negedge clk);
            if (k == 15) begin
                #1;
                check("to_fault_15", fault, 1'b0);
                check("sat_cnt_15", s_stall_cnt, 4'd15);
            end
            if (k == 16) begin
                #1;
                check("to_fault_16", fault, 1'b1);
            end
        end
        #1;
        check("sat_cnt_20", s_stall_cnt, 4'd15);
        check("big_cnt_20", stall_cnt, 16'd20);
        mem_req = 1'b0; mem_ack = 1'b1; ex_br_taken = 1'b1;
        #1;
        check("fault_hold_en", en_v(), 5'b00000);
        check("fault_hold_flush", fl_v(), 2'b00);
        @(negedge clk);
        #1;
        check("fault_sticky", fault, 1'b1);
        do_reset();
        check("fault_clr", fault, 1'b0);
        check("fault_clr_en", en_v(), 5'b11111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
